// File: rtl/slice_permute_pipe.sv
// Registered lane-permutation stage: pass / lane reverse / lane rotate / per-lane bit reverse,
// with a valid/ready handshake and a 2-entry skid buffer for full throughput under backpressure.
module slice_permute_pipe #(
   parameter int unsigned LANE_W = 8,
   parameter int unsigned LANES  = 2,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned W     = LANE_W * LANES,
   localparam int unsigned RW    = (LANES < 2) ? 1 : $clog2(LANES)
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic [W-1:0]     in_data,
   input  logic [1:0]       in_mode,
   input  logic [RW-1:0]    in_rot,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] beat_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic [W-1:0] perm_c;
   logic [W-1:0] skid_q;
   logic         accept_c;
   logic         deliver_c;
   logic         load_out_perm_c;
   logic         load_out_skid_c;
   logic         load_skid_c;

   assign accept_c  = in_valid & in_ready;
   assign deliver_c = out_valid & out_ready;

   // Lane permutation of the incoming beat; rotate amount is reduced modulo LANES.
   always_comb begin
      int unsigned src;
      perm_c = '0;
      src    = 0;
      for (int unsigned i = 0; i < LANES; i++) begin
         case (in_mode)
            2'd0: src = i;
            2'd1: src = LANES - 1 - i;
            2'd2: src = (i + 32'(in_rot)) % LANES;
            default: src = i;
         endcase
         if (in_mode == 2'd3) begin
            for (int unsigned j = 0; j < LANE_W; j++) begin
               perm_c[i*LANE_W + j] = in_data[i*LANE_W + (LANE_W - 1 - j)];
            end
         end else begin
            perm_c[i*LANE_W +: LANE_W] = in_data[src*LANE_W +: LANE_W];
         end
      end
   end

   // State register
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state <= EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         EMPTY: if (accept_c) state_nx = ONE;
         ONE: begin
            if (accept_c && !deliver_c) begin
               state_nx = TWO;
            end else if (!accept_c && deliver_c) begin
               state_nx = EMPTY;
            end
         end
         TWO: if (deliver_c) state_nx = ONE;
         default: state_nx = EMPTY;
      endcase
   end

   // Datapath load controls
   always_comb begin
      load_out_perm_c = 1'b0;
      load_out_skid_c = 1'b0;
      load_skid_c     = 1'b0;
      case (state)
         EMPTY: load_out_perm_c = accept_c;
         ONE: begin
            load_out_perm_c = accept_c & deliver_c;
            load_skid_c     = accept_c & ~deliver_c;
         end
         TWO: load_out_skid_c = deliver_c;
         default: ;
      endcase
   end

   // Output, skid and counter registers; handshake flags mirror the next state.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         out_data  <= '0;
         skid_q    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         beat_cnt  <= '0;
      end else begin
         if (load_out_perm_c) begin
            out_data <= perm_c;
         end else if (load_out_skid_c) begin
            out_data <= skid_q;
         end
         if (load_skid_c) begin
            skid_q <= perm_c;
         end
         out_valid <= (state_nx != EMPTY);
         in_ready  <= (state_nx != TWO);
         if (deliver_c) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_slice_permute_pipe.sv
// Directed bench for slice_permute_pipe: a 2-lane instance (4-bit counter) and a 4-lane instance.
module tb_slice_permute_pipe;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   logic [15:0] a_in_data;
   logic [1:0]  a_in_mode;
   logic [0:0]  a_in_rot;
   logic        a_in_valid;
   logic        a_in_ready;
   logic [15:0] a_out_data;
   logic        a_out_valid;
   logic        a_out_ready;
   logic [3:0]  a_beat_cnt;

   logic [31:0] b_in_data;
   logic [1:0]  b_in_mode;
   logic [1:0]  b_in_rot;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [31:0] b_out_data;
   logic        b_out_valid;
   logic        b_out_ready;
   logic [15:0] b_beat_cnt;

   slice_permute_pipe #(.LANE_W(8), .LANES(2), .CNT_W(4)) u_dut_a (
      .CLK         (clk),
      .ASYNCRESETN (rst_n),
      .in_data     (a_in_data),
      .in_mode     (a_in_mode),
      .in_rot      (a_in_rot),
      .in_valid    (a_in_valid),
      .in_ready    (a_in_ready),
      .out_data    (a_out_data),
      .out_valid   (a_out_valid),
      .out_ready   (a_out_ready),
      .beat_cnt    (a_beat_cnt)
   );

   slice_permute_pipe #(.LANE_W(8), .LANES(4), .CNT_W(16)) u_dut_b (
      .CLK         (clk),
      .ASYNCRESETN (rst_n),
      .in_data     (b_in_data),
      .in_mode     (b_in_mode),
      .in_rot      (b_in_rot),
      .in_valid    (b_in_valid),
      .in_ready    (b_in_ready),
      .out_data    (b_out_data),
      .out_valid   (b_out_valid),
      .out_ready   (b_out_ready),
      .beat_cnt    (b_beat_cnt)
   );

   task automatic do_reset();
      rst_n       = 1'b0;
      a_in_valid  = 1'b0;
      a_in_data   = '0;
      a_in_mode   = '0;
      a_in_rot    = '0;
      a_out_ready = 1'b0;
      b_in_valid  = 1'b0;
      b_in_data   = '0;
      b_in_mode   = '0;
      b_in_rot    = '0;
      b_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One beat through instance a with out_ready high; returns what appeared one cycle later.
   task automatic send_a(input logic [15:0] d, input logic [1:0] m, input logic [0:0] r,
                         output logic [15:0] got, output logic vld);
      a_in_valid  = 1'b1;
      a_in_data   = d;
      a_in_mode   = m;
      a_in_rot    = r;
      a_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      got        = a_out_data;
      vld        = a_out_valid;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_b(input logic [31:0] d, input logic [1:0] m, input logic [1:0] r,
                         output logic [31:0] got, output logic vld);
      b_in_valid  = 1'b1;
      b_in_data   = d;
      b_in_mode   = m;
      b_in_rot    = r;
      b_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
      got        = b_out_data;
      vld        = b_out_valid;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
      total++; if (a_out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", a_out_data); end
      total++; if (a_beat_cnt !== 4'd0) begin bad++; $display("FAIL reset_beat_cnt got=%0d exp=0", a_beat_cnt); end
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
      total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_b got valid=%b ready=%b exp valid=0 ready=1", b_out_valid, b_in_ready);
      end
   endtask

   task automatic test_lane_swap();
      logic [15:0] got;
      logic        vld;
      do_reset();
      send_a(16'hA1B2, 2'd1, 1'b0, got, vld);
      total++; if (vld !== 1'b1) begin bad++; $display("FAIL swap_latency got=%b exp=1", vld); end
      total++; if (got !== 16'hB2A1) begin bad++; $display("FAIL swap_data got=%h exp=b2a1", got); end
      total++; if (a_beat_cnt !== 4'd1) begin bad++; $display("FAIL swap_beat_cnt got=%0d exp=1", a_beat_cnt); end
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL swap_drain got=%b exp=0", a_out_valid); end
   endtask

   task automatic test_modes_two_lane();
      logic [15:0] got;
      logic        vld;
      send_a(16'h0180, 2'd3, 1'b0, got, vld);
      total++; if (got !== 16'h8001) begin bad++; $display("FAIL bitrev_data got=%h exp=8001", got); end
      send_a(16'h1234, 2'd0, 1'b0, got, vld);
      total++; if (got !== 16'h1234) begin bad++; $display("FAIL pass_data got=%h exp=1234", got); end
      send_a(16'h1234, 2'd2, 1'b1, got, vld);
      total++; if (got !== 16'h3412) begin bad++; $display("FAIL rot1_two_lane got=%h exp=3412", got); end
      send_a(16'h1234, 2'd2, 1'b0, got, vld);
      total++; if (got !== 16'h1234) begin bad++; $display("FAIL rot0_two_lane got=%h exp=1234", got); end
   endtask

   task automatic test_rotate_four_lane();
      logic [31:0] got;
      logic        vld;
      send_b(32'h44332211, 2'd2, 2'd1, got, vld);
      total++; if (vld !== 1'b1 || got !== 32'h11443322) begin
         bad++; $display("FAIL rot1_four_lane got=%h vld=%b exp=11443322", got, vld);
      end
      send_b(32'h44332211, 2'd2, 2'(5), got, vld);
      total++; if (got !== 32'h11443322) begin bad++; $display("FAIL rot5_four_lane got=%h exp=11443322", got); end
      send_b(32'h44332211, 2'd2, 2'd2, got, vld);
      total++; if (got !== 32'h22114433) begin bad++; $display("FAIL rot2_four_lane got=%h exp=22114433", got); end
      send_b(32'h44332211, 2'd1, 2'd3, got, vld);
      total++; if (got !== 32'h11223344) begin bad++; $display("FAIL rev_four_lane got=%h exp=11223344", got); end
      send_b(32'h08040201, 2'd3, 2'd0, got, vld);
      total++; if (got !== 32'h10204080) begin bad++; $display("FAIL bitrev_four_lane got=%h exp=10204080", got); end
      total++; if (b_beat_cnt !== 16'd5) begin bad++; $display("FAIL beat_cnt_four_lane got=%0d exp=5", b_beat_cnt); end
   endtask

   task automatic test_backpressure();
      logic [15:0] bd[6]     = '{16'hA1B2, 16'hA1B2, 16'h0180, 16'h1234, 16'h1234, 16'h00F0};
      logic [1:0]  bm[6]     = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3};
      logic [0:0]  br[6]     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] exp_q[6]  = '{16'hA1B2, 16'hB2A1, 16'h8001, 16'h3412, 16'h1234, 16'h000F};
      logic        ordy[12]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
      logic        rdy_e[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
      int          sent = 0;
      int          rcv  = 0;
      logic        acc;
      do_reset();
      for (int t = 0; t < 12; t++) begin
         a_out_ready = ordy[t];
         if (sent < 6) begin
            a_in_valid = 1'b1;
            a_in_data  = bd[sent];
            a_in_mode  = bm[sent];
            a_in_rot   = br[sent];
         end else begin
            a_in_valid = 1'b0;
         end
         if (t < 10) begin
            total++;
            if (a_in_ready !== rdy_e[t]) begin
               bad++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=%b", t, a_in_ready, rdy_e[t]);
            end
         end
         if (t == 3 || t == 4) begin
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== 16'hB2A1) begin
               bad++; $display("FAIL bp_hold cycle=%0d got=%h vld=%b exp=b2a1", t, a_out_data, a_out_valid);
            end
         end
         acc = a_in_valid & a_in_ready;
         if (a_out_valid && a_out_ready) begin
            if (rcv < 6) begin
               total++;
               if (a_out_data !== exp_q[rcv]) begin
                  bad++; $display("FAIL bp_order beat=%0d got=%h exp=%h", rcv, a_out_data, exp_q[rcv]);
               end
            end
            rcv++;
         end
         @(posedge clk);
         if (acc) sent++;
         @(negedge clk);
      end
      total++; if (rcv != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", rcv); end
      total++; if (a_beat_cnt !== 4'd6) begin bad++; $display("FAIL bp_beat_cnt got=%0d exp=6", a_beat_cnt); end
   endtask

   task automatic test_back_to_back_wrap();
      logic [15:0] got;
      logic        vld;
      do_reset();
      a_out_ready = 1'b1;
      a_in_mode   = 2'd0;
      a_in_rot    = 1'b0;
      for (int k = 0; k < 15; k++) begin
         a_in_valid = 1'b1;
         a_in_data  = 16'(k);
         if (k > 0) begin
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== 16'(k - 1) || a_in_ready !== 1'b1) begin
               bad++; $display("FAIL b2b_beat k=%0d got=%h vld=%b rdy=%b exp=%h", k, a_out_data, a_out_valid, a_in_ready, 16'(k - 1));
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      a_in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if (a_beat_cnt !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d exp=15", a_beat_cnt); end
      send_a(16'h0F0F, 2'd0, 1'b0, got, vld);
      total++; if (a_beat_cnt !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", a_beat_cnt); end
   endtask

   task automatic test_reset_in_two();
      logic [15:0] got;
      logic        vld;
      do_reset();
      send_a(16'h5A5A, 2'd0, 1'b0, got, vld);
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_mode   = 2'd0;
      a_in_data   = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      a_in_data = 16'h2222;
      @(posedge clk);
      @(negedge clk);
      a_in_valid = 1'b0;
      total++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 16'h1111 || a_beat_cnt !== 4'd1) begin
         bad++; $display("FAIL two_state got rdy=%b vld=%b data=%h cnt=%0d exp rdy=0 vld=1 data=1111 cnt=1",
                         a_in_ready, a_out_valid, a_out_data, a_beat_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid got=%b exp=0", a_out_valid); end
      total++; if (a_beat_cnt !== 4'd0) begin bad++; $display("FAIL async_beat_cnt got=%0d exp=0", a_beat_cnt); end
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL async_in_ready got=%b exp=1", a_in_ready); end
      total++; if (a_out_data !== 16'h0000) begin bad++; $display("FAIL async_out_data got=%h exp=0000", a_out_data); end
      @(negedge clk);
      rst_n = 1'b1;
      send_a(16'hC33C, 2'd1, 1'b0, got, vld);
      total++; if (vld !== 1'b1 || got !== 16'h3CC3) begin
         bad++; $display("FAIL post_reset_beat got=%h vld=%b exp=3cc3", got, vld);
      end
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_drain got=%b exp=0", a_out_valid); end
   endtask

   initial begin
      test_reset();
      test_lane_swap();
      test_modes_two_lane();
      test_rotate_four_lane();
      test_backpressure();
      test_back_to_back_wrap();
      test_reset_in_two();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
